// File: rtl/sd_cmd_pkg.sv
// Shared requester ids, arbiter state encoding and command/response bundles
// used by the SDIO CMD arbiter and its per-requester slots.
package sd_cmd_pkg;

   localparam logic REQ_R = 1'b0;
   localparam logic REQ_W = 1'b1;

   localparam logic [15:0] DEF_RST_CLKDIV = 16'd192;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic [15:0] clkdiv;
      logic [15:0] precnt;
      logic [5:0]  cmd;
      logic [31:0] arg;
   } cmd_req_t;

   typedef struct packed {
      logic        timeout;
      logic        syntaxe;
      logic [31:0] resparg;
   } cmd_rsp_t;

   // With both pending the requester that did not hold the last grant wins.
   function automatic logic rr_pick(input logic last, input logic pend_r, input logic pend_w);
      if (pend_r && pend_w) begin
         return ~last;
      end
      return pend_w ? REQ_W : REQ_R;
   endfunction

endpackage

// File: rtl/sd_cmd_req_slot.sv
// One requester's pending command slot plus its latched response registers.
// A start is taken only while the requester is neither pending nor in flight.
module sd_cmd_req_slot
   import sd_cmd_pkg::*;
(
   input  logic     clk,
   input  logic     rstn,
   input  logic     start_i,
   input  cmd_req_t req_i,
   input  logic     inflight_i,
   input  logic     clr_i,
   input  logic     rsp_ld_i,
   input  cmd_rsp_t rsp_i,
   output logic     pend_o,
   output logic     busy_o,
   output cmd_req_t req_o,
   output cmd_rsp_t rsp_o
);

   logic     pend_q, pend_d;
   cmd_req_t req_q, req_d;
   cmd_rsp_t rsp_q, rsp_d;
   logic     accept;

   always_comb begin
      accept = start_i & ~pend_q & ~inflight_i;
      pend_d = pend_q;
      req_d  = req_q;
      rsp_d  = rsp_q;
      if (clr_i) begin
         pend_d = 1'b0;
      end
      if (accept) begin
         pend_d = 1'b1;
         req_d  = req_i;
      end
      if (rsp_ld_i) begin
         rsp_d = rsp_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q <= 1'b0;
         req_q  <= '0;
         rsp_q  <= '0;
      end else begin
         pend_q <= pend_d;
         req_q  <= req_d;
         rsp_q  <= rsp_d;
      end
   end

   assign pend_o = pend_q;
   assign busy_o = pend_q | inflight_i;
   assign req_o  = req_q;
   assign rsp_o  = rsp_q;

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Shares one SDIO CMD controller between the sector reader (R) and writer (W):
// round-robin grant, optional writer lock, and a watchdog on the response.
module sd_cmd_arbiter
   import sd_cmd_pkg::*;
#(
   parameter int unsigned       WDOG_W      = 24,
   parameter logic [WDOG_W-1:0] WDOG_CYCLES = 24'd4000000,
   parameter logic [15:0]       RST_CLKDIV  = DEF_RST_CLKDIV
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] r_clkdiv,
   input  logic        r_start,
   input  logic [15:0] r_precnt,
   input  logic [5:0]  r_cmd,
   input  logic [31:0] r_arg,
   output logic        r_busy,
   output logic        r_done,
   output logic        r_timeout,
   output logic        r_syntaxe,
   output logic [31:0] r_resparg,
   input  logic [15:0] w_clkdiv,
   input  logic        w_start,
   input  logic [15:0] w_precnt,
   input  logic [5:0]  w_cmd,
   input  logic [31:0] w_arg,
   output logic        w_busy,
   output logic        w_done,
   output logic        w_timeout,
   output logic        w_syntaxe,
   output logic [31:0] w_resparg,
   input  logic        w_lock,
   output logic [15:0] m_clkdiv,
   output logic        m_start,
   output logic [15:0] m_precnt,
   output logic [5:0]  m_cmd,
   output logic [31:0] m_arg,
   input  logic        m_busy,
   input  logic        m_done,
   input  logic        m_timeout,
   input  logic        m_syntaxe,
   input  logic [31:0] m_resparg,
   output logic        owner
);

   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_CYCLES - WDOG_W'(1);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   cmd_req_t          mreq_q, mreq_d;

   cmd_req_t r_req_in, w_req_in, r_slot_req, w_slot_req;
   cmd_rsp_t r_slot_rsp, w_slot_rsp, rsp_val;
   logic     pend_r, pend_w;
   logic     go, sel, rsp_ld;
   logic     r_inflight, w_inflight, r_clr, w_clr, r_rsp_ld, w_rsp_ld;

   assign r_req_in = '{clkdiv: r_clkdiv, precnt: r_precnt, cmd: r_cmd, arg: r_arg};
   assign w_req_in = '{clkdiv: w_clkdiv, precnt: w_precnt, cmd: w_cmd, arg: w_arg};

   sd_cmd_req_slot u_slot_r (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (r_start),
      .req_i      (r_req_in),
      .inflight_i (r_inflight),
      .clr_i      (r_clr),
      .rsp_ld_i   (r_rsp_ld),
      .rsp_i      (rsp_val),
      .pend_o     (pend_r),
      .busy_o     (r_busy),
      .req_o      (r_slot_req),
      .rsp_o      (r_slot_rsp)
   );

   sd_cmd_req_slot u_slot_w (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (w_start),
      .req_i      (w_req_in),
      .inflight_i (w_inflight),
      .clr_i      (w_clr),
      .rsp_ld_i   (w_rsp_ld),
      .rsp_i      (rsp_val),
      .pend_o     (pend_w),
      .busy_o     (w_busy),
      .req_o      (w_slot_req),
      .rsp_o      (w_slot_rsp)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= REQ_R;
         wdog_q  <= '0;
         mreq_q  <= '{clkdiv: RST_CLKDIV, precnt: '0, cmd: '0, arg: '0};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wdog_q  <= wdog_d;
         mreq_q  <= mreq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wdog_d  = wdog_q;
      mreq_d  = mreq_q;
      go      = 1'b0;
      sel     = owner_q;
      rsp_ld  = 1'b0;
      rsp_val = '0;
      case (state_q)
         IDLE: begin
            if (!m_busy) begin
               if (w_lock && owner_q == REQ_W) begin
                  go  = pend_w;
                  sel = REQ_W;
               end else begin
                  go  = pend_r | pend_w;
                  sel = rr_pick(owner_q, pend_r, pend_w);
               end
            end
            // The whole controller-side bundle is loaded here so that
            // m_clkdiv never moves while a command is outstanding.
            if (go) begin
               owner_d = sel;
               mreq_d  = (sel == REQ_W) ? w_slot_req : r_slot_req;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wdog_d  = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (m_done) begin
               rsp_ld  = 1'b1;
               rsp_val = '{timeout: m_timeout, syntaxe: m_syntaxe, resparg: m_resparg};
               state_d = RESP;
            end else if (wdog_q == WDOG_LAST) begin
               rsp_ld  = 1'b1;
               rsp_val = '{timeout: 1'b1, syntaxe: 1'b0, resparg: '0};
               state_d = RESP;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      m_start    = (state_q == ISSUE);
      r_inflight = (state_q != IDLE) && (owner_q == REQ_R);
      w_inflight = (state_q != IDLE) && (owner_q == REQ_W);
      r_clr      = (state_q == ISSUE) && (owner_q == REQ_R);
      w_clr      = (state_q == ISSUE) && (owner_q == REQ_W);
      r_rsp_ld   = rsp_ld && (owner_q == REQ_R);
      w_rsp_ld   = rsp_ld && (owner_q == REQ_W);
      r_done     = (state_q == RESP) && (owner_q == REQ_R);
      w_done     = (state_q == RESP) && (owner_q == REQ_W);
   end

   assign m_clkdiv  = mreq_q.clkdiv;
   assign m_precnt  = mreq_q.precnt;
   assign m_cmd     = mreq_q.cmd;
   assign m_arg     = mreq_q.arg;
   assign owner     = owner_q;

   assign r_timeout = r_slot_rsp.timeout;
   assign r_syntaxe = r_slot_rsp.syntaxe;
   assign r_resparg = r_slot_rsp.resparg;
   assign w_timeout = w_slot_rsp.timeout;
   assign w_syntaxe = w_slot_rsp.syntaxe;
   assign w_resparg = w_slot_rsp.resparg;

endmodule
